instruction_fetch: RTL

Fetch stage directly downstream of `programcounter`: consumes its `pcout`, reads 32-bit instruction words from instruction memory over a single-outstanding req/ack handshake, and queues them with their PC in a small FIFO for the decode stage. It tells `programcounter` when to step sequentially. On a control-flow redirect it flushes the queue and drops any in-flight fetch.

---
 rtl/instruction_fetch_if.sv | 23 ++
 rtl/instruction_fetch.sv | 137 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read handshake plus the
// decode-facing instruction queue head.
interface instruction_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc, instr_fault,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc, instr_fault,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction-memory reads queued with their
// PC in a small FIFO for decode; redirect flushes the queue and drops fetches.
module instruction_fetch #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         pcin,
  input  logic                redirect,
  output logic                advance,
  instruction_fetch_if.master fetch
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("instruction_fetch: DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {IDLE, REQ, DROP, FAULT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count, count_nx;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  entry_t          store [DEPTH];

  logic            space_c;
  logic            launch_c;
  logic            push_c;
  logic            pop_c;
  entry_t          push_data_c;

  assign space_c = (count < CW'(DEPTH));
  assign pop_c   = fetch.instr_valid && fetch.instr_ready;

  // Next-state, push decision and PC-step request
  always_comb begin
    state_nx    = state;
    launch_c    = 1'b0;
    push_c      = 1'b0;
    push_data_c = '0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && space_c) begin
          if (pcin[1:0] == 2'b00) begin
            launch_c = 1'b1;
            state_nx = REQ;
          end else begin
            push_c      = 1'b1;
            push_data_c = '{instr: NOP, pc: pcin, fault: 1'b1};
            state_nx    = FAULT;
          end
        end
      end
      REQ: begin
        if (fetch.mem_ack) begin
          if (!redirect) begin
            push_c      = 1'b1;
            push_data_c = '{instr: fetch.mem_rdata, pc: fetch.mem_addr, fault: 1'b0};
            advance     = 1'b1;
          end
          state_nx = IDLE;
        end else if (redirect) begin
          state_nx = DROP;
        end
      end
      DROP: begin
        if (fetch.mem_ack) state_nx = IDLE;
      end
      FAULT: begin
        if (redirect) state_nx = IDLE;
      end
    endcase
  end

  // State and memory request registers; address held through REQ and DROP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fetch.mem_req  <= 1'b0;
      fetch.mem_addr <= '0;
    end else begin
      state         <= state_nx;
      fetch.mem_req <= (state_nx == REQ) || (state_nx == DROP);
      if (launch_c) fetch.mem_addr <= pcin;
    end
  end

  // Occupancy: flush wins over push/pop; push+pop together leaves count as is
  always_comb begin
    count_nx = count;
    if (redirect) begin
      count_nx = '0;
    end else if (push_c && !pop_c) begin
      count_nx = count + CW'(1);
    end else if (!push_c && pop_c) begin
      count_nx = count - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count             <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fetch.instr_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      count             <= count_nx;
      fetch.instr_valid <= (count_nx != '0);
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) begin
          store[wr_ptr] <= push_data_c;
          wr_ptr        <= wr_ptr + PW'(1);
        end
        if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign fetch.instr       = store[rd_ptr].instr;
  assign fetch.instr_pc    = store[rd_ptr].pc;
  assign fetch.instr_fault = store[rd_ptr].fault;

endmodule
